// File: rtl/multi_mode_scope.sv
// multi_mode_scope: internal logic analyser with a circular capture buffer.
//
// Arming latches the trigger configuration and starts a fresh capture. The
// buffer is first filled once (primed). After that, a pattern trigger (level,
// rising, falling or any-change on masked bits) or a forced trigger marks the
// trigger sample. Exactly `holdoff` further samples are written, then writing
// stops and the DEPTH stored samples stream out oldest-first.
//
// Ports:
//   clk, reset          rising-edge clock; asynchronous active-low reset
//   i_arm               one-cycle pulse: latch config, restart capture
//   i_force_trigger     manual trigger (honoured only once primed)
//   i_trig_mask/value   masked compare pattern
//   i_trig_mode         00 level, 01 rising, 10 falling, 11 any-change
//   i_holdoff           samples written after the trigger sample
//   i_data              observed signals
//   o_primed            buffer filled once since arm
//   o_triggered         trigger accepted for current capture
//   o_stopped           writing halted, buffer readable
//   o_trig_addr         buffer address of the trigger sample
//   o_rd_valid/data/last, i_rd_ready   readout stream (valid/ready)
module multi_mode_scope #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDR_WIDTH    = 4,
  parameter int unsigned HOLDOFF_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_arm,
  input  logic                     i_force_trigger,
  input  logic [DATA_WIDTH-1:0]    i_trig_mask,
  input  logic [DATA_WIDTH-1:0]    i_trig_value,
  input  logic [1:0]               i_trig_mode,
  input  logic [HOLDOFF_WIDTH-1:0] i_holdoff,
  input  logic [DATA_WIDTH-1:0]    i_data,
  output logic                     o_primed,
  output logic                     o_triggered,
  output logic                     o_stopped,
  output logic [ADDR_WIDTH-1:0]    o_trig_addr,
  output logic                     o_rd_valid,
  output logic [DATA_WIDTH-1:0]    o_rd_data,
  output logic                     o_rd_last,
  input  logic                     i_rd_ready
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StPrimed,
    StHoldoff,
    StDone
  } state_e;

  state_e                   state_q;
  logic [ADDR_WIDTH-1:0]    waddr_q;
  logic [DATA_WIDTH-1:0]    mask_q;
  logic [DATA_WIDTH-1:0]    value_q;
  logic [1:0]               mode_q;
  logic [HOLDOFF_WIDTH-1:0] holdoff_q;
  logic [HOLDOFF_WIDTH-1:0] hcnt_q;
  logic [DATA_WIDTH-1:0]    prev_q;
  logic                     primed_q;
  logic                     triggered_q;
  logic                     stopped_q;
  logic [ADDR_WIDTH-1:0]    trig_addr_q;

  // Readout pipeline: RAM read register (stage 1) feeding the output register.
  logic [ADDR_WIDTH:0]      rd_issued_q;
  logic                     s1_valid_q;
  logic                     s1_last_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic                     out_valid_q;
  logic                     out_last_q;
  logic [DATA_WIDTH-1:0]    out_data_q;

  logic [DATA_WIDTH-1:0]    ram [Depth];

  logic                     lvl_cur;
  logic                     lvl_prev;
  logic                     pat_match;
  logic                     trig;
  logic                     we;
  logic                     load_out;
  logic                     rd_en;
  logic                     rd_is_last;
  logic [ADDR_WIDTH-1:0]    rd_addr;

  always_comb begin
    lvl_cur  = ((i_data ^ value_q) & mask_q) == '0;
    lvl_prev = ((prev_q ^ value_q) & mask_q) == '0;
    case (mode_q)
      2'b00:   pat_match = lvl_cur;
      2'b01:   pat_match = lvl_cur & ~lvl_prev;
      2'b10:   pat_match = lvl_prev & ~lvl_cur;
      2'b11:   pat_match = ((i_data ^ prev_q) & mask_q) != '0;
      default: pat_match = 1'b0;
    endcase
    // An all-zero mask disables the pattern trigger in every mode.
    trig = ((mask_q != '0) & pat_match) | i_force_trigger;

    we = ~i_arm & ((state_q == StFill) | (state_q == StPrimed) | (state_q == StHoldoff));

    load_out   = s1_valid_q & (~out_valid_q | i_rd_ready);
    // Issue a read whenever stage 1 is empty or is draining this cycle.
    rd_en      = ~i_arm & (state_q == StDone) & ~rd_issued_q[ADDR_WIDTH] &
                 (~s1_valid_q | load_out);
    rd_is_last = rd_issued_q[ADDR_WIDTH-1:0] == '1;
    // Oldest sample sits at the frozen write pointer.
    rd_addr    = waddr_q + rd_issued_q[ADDR_WIDTH-1:0];
  end

  // Capture memory; contents need no reset.
  always_ff @(posedge clk) begin
    if (we) begin
      ram[waddr_q] <= i_data;
    end
    if (rd_en) begin
      rdata_q <= ram[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      waddr_q     <= '0;
      mask_q      <= '0;
      value_q     <= '0;
      mode_q      <= '0;
      holdoff_q   <= '0;
      hcnt_q      <= '0;
      prev_q      <= '0;
      primed_q    <= 1'b0;
      triggered_q <= 1'b0;
      stopped_q   <= 1'b0;
      trig_addr_q <= '0;
      rd_issued_q <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      prev_q <= i_data;
      if (i_arm) begin
        mask_q      <= i_trig_mask;
        value_q     <= i_trig_value;
        mode_q      <= i_trig_mode;
        holdoff_q   <= i_holdoff;
        waddr_q     <= '0;
        hcnt_q      <= '0;
        primed_q    <= 1'b0;
        triggered_q <= 1'b0;
        stopped_q   <= 1'b0;
        trig_addr_q <= '0;
        rd_issued_q <= '0;
        s1_valid_q  <= 1'b0;
        s1_last_q   <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        out_data_q  <= '0;
        state_q     <= StFill;
      end else begin
        if (we) begin
          waddr_q <= waddr_q + 1'b1;
        end
        case (state_q)
          StFill: begin
            if (waddr_q == '1) begin
              primed_q <= 1'b1;
              state_q  <= StPrimed;
            end
          end
          StPrimed: begin
            if (trig) begin
              trig_addr_q <= waddr_q;
              triggered_q <= 1'b1;
              if (holdoff_q == '0) begin
                stopped_q <= 1'b1;
                state_q   <= StDone;
              end else begin
                hcnt_q  <= holdoff_q;
                state_q <= StHoldoff;
              end
            end
          end
          StHoldoff: begin
            hcnt_q <= hcnt_q - 1'b1;
            if (hcnt_q == HOLDOFF_WIDTH'(1)) begin
              stopped_q <= 1'b1;
              state_q   <= StDone;
            end
          end
          StDone: begin
            if (rd_en) begin
              rd_issued_q <= rd_issued_q + 1'b1;
              s1_valid_q  <= 1'b1;
              s1_last_q   <= rd_is_last;
            end else if (load_out) begin
              s1_valid_q <= 1'b0;
            end
            if (load_out) begin
              out_valid_q <= 1'b1;
              out_data_q  <= rdata_q;
              out_last_q  <= s1_last_q;
            end else if (i_rd_ready) begin
              out_valid_q <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_primed    = primed_q;
  assign o_triggered = triggered_q;
  assign o_stopped   = stopped_q;
  assign o_trig_addr = trig_addr_q;
  assign o_rd_valid  = out_valid_q;
  assign o_rd_data   = out_data_q;
  assign o_rd_last   = out_last_q;

endmodule
